cache_fill_arbiter: RTL
=======================

Name: cache_fill_arbiter

Overview:
- Shares the single main-memory port between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sequences each 8-word block fill and drives per-word fill strobes into the owning cache.
- Generates the stall enables that freeze the fetch-side and memory-side pipeline registers while a request is outstanding.

Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block; power of two.
- MEM_LAT, 4: cycles from memory read issue to the matching mem_valid. Used only by the bench model; the RTL tracks mem_valid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_miss  in  1  I-cache miss pending; level, held until fill_done_i.
- icache_addr  in  16  miss byte address.
- dcache_miss  in  1  D-cache miss pending; level, held until fill_done_d.
- dcache_addr  in  16  miss byte address.
- dcache_wr  in  1  store write-through request; level, held until wr_ack.
- dcache_wr_addr  in  16  store byte address.
- dcache_wr_data  in  16  store data.
- mem_en  out  1  memory request valid this cycle.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read return data.
- mem_valid  in  1  mem_rdata valid; pipelined memory, one return per issued read, in order.
- fill_data  out  16  mem_rdata forwarded to the cache.
- fill_word  out  log2(BLOCK_WORDS)  word index of fill_data.
- fill_we_i  out  1  I-cache data-array write strobe.
- fill_we_d  out  1  D-cache data-array write strobe.
- fill_done_i  out  1  one-cycle pulse: I-cache block complete; tag write.
- fill_done_d  out  1  one-cycle pulse: D-cache block complete; tag write.
- wr_ack  out  1  one-cycle pulse: store issued.
- stall_fetch  out  1  stall enable for the PC and IF/ID register.
- stall_mem  out  1  stall enable for every pipeline register up to and including EX/MEM.
- perf_istall  out  16  I-side stall-cycle count (optional feature).
- perf_dstall  out  16  D-side stall-cycle count (optional feature).

Behaviour:
- FSM states: IDLE, IFILL, DFILL, WRITE.
- Reset: state IDLE; issue_cnt, recv_cnt and last_grant cleared; every output 0.
- Arbitration in IDLE; decision registered, grant takes effect next cycle:
  - dcache_miss has priority over dcache_wr, which has priority over icache_miss.
  - Exception: if last_grant == D and icache_miss is set, go to IFILL. This prevents I-side starvation.
  - A store that misses is filled first (DFILL), then written (WRITE).
- IFILL / DFILL:
  - Issue one read per cycle: mem_en=1, mem_wr=0, mem_addr = {base[15:log2(BLOCK_WORDS)+1], issue_cnt, 1'b0}, issue_cnt 0..BLOCK_WORDS-1.
  - Stop issuing after BLOCK_WORDS reads.
  - Each mem_valid forwards fill_data=mem_rdata and fill_word=recv_cnt, pulses the owner's fill_we_*, and increments recv_cnt.
  - When the word with recv_cnt == BLOCK_WORDS-1 arrives, fill_done_* pulses in that same cycle and the FSM returns to IDLE next cycle. Counters clear and last_grant is updated.
- WRITE: one cycle; mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data, wr_ack=1. Return to IDLE; last_grant=D.
- mem_valid is ignored in IDLE and WRITE, including stale returns after reset.
- Stall outputs (combinational):
  - stall_mem = dcache_miss | (dcache_wr & ~wr_ack).
  - stall_fetch = icache_miss | stall_mem.
- Block latency: BLOCK_WORDS + MEM_LAT + 1 cycles from miss assertion to fill_done, counting the arbitration cycle.
- Reset mid-fill aborts immediately; requesters keep their miss asserted and the fill restarts from word 0.
- Write path: memory writes are posted; no response is expected.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_istall increments each cycle icache_miss=1; perf_dstall increments each cycle stall_mem=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: both ports tied to 0 and no counter logic is present.

Test Plan:
- I-fill: icache_miss=1, addr=16'h1234, MEM_LAT=4.
  - Expect reads to 16'h1230..16'h123E.
  - Expect 8 fill_we_i pulses with fill_word 0..7.
  - Expect fill_done_i in cycle 13.
  - stall_fetch=1 throughout; stall_mem=0.
- Concurrent misses: icache_miss and dcache_miss both rise in the same cycle.
  - DFILL runs first, then IFILL, which must win over a new dcache_miss raised during DFILL (starvation rule).
- Store: dcache_wr=1, addr=16'h0040, data=16'hBEEF, in IDLE.
  - Next cycle: mem_en=1, mem_wr=1, mem_wdata=16'hBEEF, wr_ack=1.
  - stall_mem=1 for exactly 1 cycle.
- Store miss: dcache_miss and dcache_wr set together; expect the full DFILL, then one WRITE cycle, then wr_ack.
- Reset at word 3 of a DFILL:
  - All outputs 0 and state IDLE immediately.
  - A late mem_valid is ignored.
  - After release, the fill restarts from fill_word 0.
- With ARB_PERF_CNT_EN defined: one I-fill plus one store gives perf_istall=13 and perf_dstall=1. Without the macro, both read 0.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// Memory-port arbiter for I-cache fills, D-cache fills and D-cache write-through stores.
// Optional stall-cycle performance counters are enabled by defining ARB_PERF_CNT_EN.
module cache_fill_arbiter #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned MEM_LAT     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           icache_miss,
  input  logic [15:0]                    icache_addr,
  input  logic                           dcache_miss,
  input  logic [15:0]                    dcache_addr,
  input  logic                           dcache_wr,
  input  logic [15:0]                    dcache_wr_addr,
  input  logic [15:0]                    dcache_wr_data,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_valid,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           fill_we_i,
  output logic                           fill_we_d,
  output logic                           fill_done_i,
  output logic                           fill_done_d,
  output logic                           wr_ack,
  output logic                           stall_fetch,
  output logic                           stall_mem,
  output logic [15:0]                    perf_istall,
  output logic [15:0]                    perf_dstall
);

  localparam int unsigned WB = $clog2(BLOCK_WORDS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IFILL = 2'd1;
  localparam logic [1:0] DFILL = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_param_check
    $error("cache_fill_arbiter: BLOCK_WORDS must be a power of two >= 2 and MEM_LAT >= 1");
  end

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [WB:0]    issue_cnt;
  logic [WB-1:0]  recv_cnt;
  logic           last_grant;
  logic [15:WB+1] base;
  logic           filling;
  logic           issuing;
  logic           fill_hit;
  logic           fill_last;

  // Low address bits select a byte/word inside the block and are regenerated from issue_cnt.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_addr[WB:0], dcache_addr[WB:0]};

  assign filling   = (state == IFILL) || (state == DFILL);
  assign issuing   = filling && !issue_cnt[WB];
  assign fill_hit  = filling && mem_valid;
  assign fill_last = fill_hit && (recv_cnt == WB'(BLOCK_WORDS - 1));

  // The anti-starvation check precedes the fixed D-miss > store > I-miss priority.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (last_grant == GRANT_D && icache_miss) state_nxt = IFILL;
        else if (dcache_miss)                     state_nxt = DFILL;
        else if (dcache_wr)                       state_nxt = WRITE;
        else if (icache_miss)                     state_nxt = IFILL;
      end
      IFILL, DFILL: if (fill_last) state_nxt = IDLE;
      WRITE:        state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      last_grant <= GRANT_I;
      base       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == IFILL)      base <= icache_addr[15:WB+1];
          else if (state_nxt == DFILL) base <= dcache_addr[15:WB+1];
        end
        IFILL, DFILL: begin
          if (issuing)  issue_cnt <= issue_cnt + (WB+1)'(1);
          if (fill_hit) recv_cnt  <= recv_cnt + WB'(1);
          if (fill_last) begin
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            last_grant <= (state == DFILL) ? GRANT_D : GRANT_I;
          end
        end
        WRITE:   last_grant <= GRANT_D;
        default: ;
      endcase
    end
  end

  assign mem_en    = issuing || (state == WRITE);
  assign mem_wr    = (state == WRITE);
  assign mem_addr  = issuing ? {base, issue_cnt[WB-1:0], 1'b0}
                   : (state == WRITE) ? dcache_wr_addr : '0;
  assign mem_wdata = (state == WRITE) ? dcache_wr_data : '0;
  assign wr_ack    = (state == WRITE);

  assign fill_data   = fill_hit ? mem_rdata : '0;
  assign fill_word   = fill_hit ? recv_cnt : '0;
  assign fill_we_i   = fill_hit && (state == IFILL);
  assign fill_we_d   = fill_hit && (state == DFILL);
  assign fill_done_i = fill_last && (state == IFILL);
  assign fill_done_d = fill_last && (state == DFILL);

  // Gated by rst so every output reads 0 while reset is held, even with requests pending.
  assign stall_mem   = !rst && (dcache_miss || (dcache_wr && !wr_ack));
  assign stall_fetch = (!rst && icache_miss) || stall_mem;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_istall <= '0;
      perf_dstall <= '0;
    end else begin
      if (icache_miss && perf_istall != 16'hFFFF) perf_istall <= perf_istall + 16'd1;
      if (stall_mem && perf_dstall != 16'hFFFF)   perf_dstall <= perf_dstall + 16'd1;
    end
  end
`else
  assign perf_istall = '0;
  assign perf_dstall = '0;
`endif

endmodule
